// File: rtl/add_cmp_pkg.sv
// Shared constants and helpers for the pipelined adder-comparator.
package add_cmp_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int ngroups(input int width, input int group);
    return (width + group - 1) / group;
  endfunction

endpackage

// File: rtl/add_cmp_err.sv
// Carry-free equality check: err is all-zero iff a + b_i + cin_i == c (mod 2^WIDTH).
module add_cmp_err #(
  parameter int WIDTH = 50
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] err_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] k;

  // k[i] is the carry out of bit i assuming c is the correct sum, so each
  // bit only has to agree with its neighbour's assumed carry.
  assign p      = a_i ^ b_i;
  assign t      = p ^ c_i;
  assign k      = (a_i & b_i) | (p & ~c_i);
  assign err_o  = t ^ {k[WIDTH-2:0], cin_i};
  assign cout_o = k[WIDTH-1];

endmodule

// File: rtl/add_cmp_pipe.sv
// Four-stage pipelined a+b==c / a-b==c checker with bubble-collapsing valid/ready.
module add_cmp_pipe
  import add_cmp_pkg::*;
#(
  parameter int WIDTH = 50,
  parameter int GROUP = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NGRP = ngroups(WIDTH, GROUP);

  logic v1_q, v2_q, v3_q, v4_q;
  logic load1, load2, load3, load4;

  logic [WIDTH-1:0] a_q, bp_q, c_q;
  logic             cin_q;
  logic [TAG_W-1:0] tag1_q;
  logic [WIDTH-1:0] bp_d;
  logic             cin_d;

  logic [WIDTH-1:0] err_d, err_q;
  logic             cout_d, cout2_q;
  logic [TAG_W-1:0] tag2_q;

  logic [NGRP-1:0]  grp_d, grp_q;
  logic             cout3_q;
  logic [TAG_W-1:0] tag3_q;

  logic             eq_q, cout_q;
  logic [TAG_W-1:0] tag_q;

  // A stage may load when empty or when its successor is loading.
  assign load4    = ~v4_q | out_ready;
  assign load3    = ~v3_q | load4;
  assign load2    = ~v2_q | load3;
  assign load1    = ~v1_q | load2;
  assign in_ready = load1;

  assign cin_d = (in_mode == MODE_SUB);
  assign bp_d  = cin_d ? ~in_b : in_b;

  add_cmp_err #(.WIDTH(WIDTH)) u_err (
    .a_i    (a_q),
    .b_i    (bp_q),
    .c_i    (c_q),
    .cin_i  (cin_q),
    .err_o  (err_d),
    .cout_o (cout_d)
  );

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    localparam int LO = g * GROUP;
    localparam int HI = (LO + GROUP - 1 < WIDTH) ? LO + GROUP - 1 : WIDTH - 1;
    assign grp_d[g] = |err_q[HI:LO];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      v4_q   <= 1'b0;
      eq_q   <= 1'b0;
      cout_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      if (load1) v1_q <= in_valid;
      if (load2) v2_q <= v1_q;
      if (load3) v3_q <= v2_q;
      if (load4) begin
        v4_q <= v3_q;
        if (v3_q) begin
          eq_q   <= ~|grp_q;
          cout_q <= cout3_q;
          tag_q  <= tag3_q;
        end
      end
    end
  end

  // Datapath registers are qualified by their stage valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (load1) begin
      a_q    <= in_a;
      bp_q   <= bp_d;
      c_q    <= in_c;
      cin_q  <= cin_d;
      tag1_q <= in_tag;
    end
    if (load2) begin
      err_q   <= err_d;
      cout2_q <= cout_d;
      tag2_q  <= tag1_q;
    end
    if (load3) begin
      grp_q   <= grp_d;
      cout3_q <= cout2_q;
      tag3_q  <= tag2_q;
    end
  end

  assign out_valid = v4_q;
  assign out_eq    = eq_q;
  assign out_cout  = cout_q;
  assign out_tag   = tag_q;

endmodule

// File: doc/add_cmp_pipe.md
Name: add_cmp_pipe

Overview:
- Parametrised, pipelined successor to the 50-bit combinational adder-comparator.
- Tests a+b+cin == c (ADD mode) or a-b == c (SUB mode) with the carry-free equality identity, so no full carry chain is built.
- Pipelined over 4 registered stages with valid/ready flow control and a pass-through tag.
- Sits between an operand producer (e.g. address/bounds check issue logic) and a result consumer that may apply backpressure.

Parameters:
- WIDTH, 50, operand width in bits (>=2).
- GROUP, 8, bits OR-reduced per group in stage 3 (1..WIDTH).
- TAG_W, 4, width of opaque tag carried alongside each operation (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts input this cycle.
- in_mode  in  1  0=ADD (a+b==c), 1=SUB (a-b==c).
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_c  in  WIDTH  expected result c.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_eq  out  1  1 when (a op b) mod 2^WIDTH == c.
- out_cout  out  1  carry-out of a+b+cin; meaningful only when out_eq=1 (SUB: 1 means no borrow, a>=b unsigned).
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
- Operand prep:
  - ADD: b'=b, cin=0.
  - SUB: b'=~b, cin=1.
- Carry-free check:
  - t=a^b'^c; k=(a&b')|((a^b')&~c).
  - err = t ^ {k[WIDTH-2:0],cin}.
  - Equality holds iff err==0; cout=k[WIDTH-1].
- Pipeline stages, each with its own valid bit:
  - S1: register a, b', c, cin, tag.
  - S2: register err[WIDTH-1:0], k[WIDTH-1], tag.
  - S3: register grp[NGRP-1:0], NGRP=ceil(WIDTH/GROUP). grp[i] = OR of err bits in group i; the last group may be partial.
  - S4: output regs: eq = ~|grp, cout, tag.
- Latency: 4 cycles from input transfer to out_valid, absent backpressure. Throughput: 1 op/cycle.
- Flow control is bubble-collapsing:
  - Stage n loads when its own valid=0 or stage n+1 loads (S4: or out_ready).
  - in_ready = ~v1 | load2. No combinational path from in_valid to in_ready; out_ready may reach in_ready combinationally.
- Stalled stages hold data and valid unchanged. A held out_* must be stable while out_valid&~out_ready.
- Full pipeline (4 ops) with out_ready=0: in_ready=0, and no op is lost or duplicated.
- Results leave strictly in input order. Tags are returned unmodified.
- Arithmetic is modulo 2^WIDTH; c is never sign-extended. out_cout reflects the true carry-out only when out_eq=1.
- Reset (async assert, release synchronous to clk):
  - All stage valids=0; out_valid=0, out_eq=0, out_cout=0, out_tag=0.
  - Data regs in S1-S3 need no reset.
  - Reset mid-operation discards all in-flight ops.
  - in_ready=1 on the first cycle after reset release.

Decomposition:
- Package add_cmp_pkg: mode constants MODE_ADD=1'b0, MODE_SUB=1'b1; function ngroups(width, group) returning ceil.
- One natural sub-module: add_cmp_err (pure combinational: a, b', c, cin -> err, k), reused by both modes and unit-testable alone.
- Stage registers stay in add_cmp_pipe.

Test Plan:
- ADD, WIDTH=50: a=3, b=5, c=8, tag=1 -> 4 cycles later out_valid=1, out_eq=1, out_cout=0, out_tag=1. Repeat with c=9 -> out_eq=0.
- ADD wrap: a=2^50-1, b=1, c=0 -> out_eq=1, out_cout=1. SUB: a=5, b=7, c=2^50-2 -> out_eq=1, out_cout=0 (borrow). SUB: a=7, b=5, c=2 -> out_eq=1, out_cout=1.
- Streaming: 100 back-to-back random ops, ~50% forced-equal, out_ready=1 -> one result per cycle, in order, tags 0..15 wrap correctly, eq matches reference model.
- Backpressure: hold out_ready=0 while driving 6 ops -> exactly 4 accepted, in_ready=0 thereafter, out_* stable. Release -> all 6 delivered in order, none lost or duplicated.
- Random out_ready (30% low) with random in_valid for 10k ops -> scoreboard matches; in_ready never depends combinationally on in_valid.
- Assert rst_n with 3 ops in flight -> out_valid drops immediately (async), no stale result after release, in_ready=1 on the first post-reset cycle. Also rerun with WIDTH=7, GROUP=3 (partial last group) and a single-bit error in bit 6 -> out_eq=0.
